// File: rtl/seg_display_sched.sv
// Picks what the 4-digit display shows: live status or a timed message.
// One message active, one queued; optional blink while a message is shown.
module seg_display_sched #(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int BLINK_HALF  = 25_000_000,
  parameter int CNT_W       = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] status_val,
  input  logic        msg_valid,
  input  logic [15:0] msg_data,
  input  logic        msg_blink,
  output logic        msg_ready,
  input  logic        msg_clear,
  output logic [3:0]  dig0,
  output logic [3:0]  dig1,
  output logic [3:0]  dig2,
  output logic [3:0]  dig3,
  output logic        disp_on,
  output logic        busy
);

  typedef enum logic {IDLE, SHOW} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  state_t           state;
  logic [15:0]      digs;
  logic             act_blink;
  logic             pend_valid;
  logic [15:0]      pend_data;
  logic             pend_blink;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] blink_cnt;

  logic xfer;
  logic expire;

  assign msg_ready = !msg_clear && (state == IDLE || !pend_valid);
  assign xfer      = msg_valid && msg_ready;
  assign expire    = (state == SHOW) && (hold_cnt == HOLD_LAST);

  assign {dig3, dig2, dig1, dig0} = digs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      digs       <= '0;
      disp_on    <= 1'b1;
      busy       <= 1'b0;
      act_blink  <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_blink <= 1'b0;
      hold_cnt   <= '0;
      blink_cnt  <= '0;
    end else if (msg_clear) begin
      state      <= IDLE;
      digs       <= status_val;
      disp_on    <= 1'b1;
      busy       <= 1'b0;
      pend_valid <= 1'b0;
      hold_cnt   <= '0;
      blink_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          digs    <= status_val;
          disp_on <= 1'b1;
          if (xfer) begin
            state     <= SHOW;
            busy      <= 1'b1;
            digs      <= msg_data;
            act_blink <= msg_blink;
            hold_cnt  <= '0;
            blink_cnt <= '0;
          end
        end
        SHOW: begin
          if (expire) begin
            hold_cnt  <= '0;
            blink_cnt <= '0;
            disp_on   <= 1'b1;
            // A queued message chains on with no status cycle between
            if (pend_valid) begin
              digs       <= pend_data;
              act_blink  <= pend_blink;
              pend_valid <= 1'b0;
            end else if (xfer) begin
              digs      <= msg_data;
              act_blink <= msg_blink;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              digs  <= status_val;
            end
          end else begin
            hold_cnt <= hold_cnt + ONE;
            if (act_blink) begin
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                disp_on   <= ~disp_on;
              end else begin
                blink_cnt <= blink_cnt + ONE;
              end
            end else begin
              disp_on <= 1'b1;
            end
            if (xfer) begin
              pend_valid <= 1'b1;
              pend_data  <= msg_data;
              pend_blink <= msg_blink;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_sched.sv
// Scoreboard bench for seg_display_sched with HOLD_CYCLES=8, BLINK_HALF=2.
// Driver queues the expected post-edge outputs; a monitor checks them.
module tb_seg_display_sched;

  localparam int HOLD = 8;
  localparam int BH   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] status_val = '0;
  logic        msg_valid = 1'b0;
  logic [15:0] msg_data = '0;
  logic        msg_blink = 1'b0;
  logic        msg_ready;
  logic        msg_clear = 1'b0;
  logic [3:0]  dig0, dig1, dig2, dig3;
  logic        disp_on;
  logic        busy;

  typedef struct packed {
    logic [15:0] d;
    logic        on;
    logic        bz;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  seg_display_sched #(
    .HOLD_CYCLES(HOLD),
    .BLINK_HALF (BH),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .status_val(status_val),
    .msg_valid (msg_valid),
    .msg_data  (msg_data),
    .msg_blink (msg_blink),
    .msg_ready (msg_ready),
    .msg_clear (msg_clear),
    .dig0      (dig0),
    .dig1      (dig1),
    .dig2      (dig2),
    .dig3      (dig3),
    .disp_on   (disp_on),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // One clock: drive inputs, check msg_ready, queue the post-edge outputs.
  task automatic cyc(input logic [15:0] sv, input logic v,
                     input logic [15:0] md, input logic bl,
                     input logic clr, input logic rdy,
                     input logic [15:0] ed, input logic eon,
                     input logic ebz);
    exp_t e;
    @(negedge clk);
    status_val = sv;
    msg_valid  = v;
    msg_data   = md;
    msg_blink  = bl;
    msg_clear  = clr;
    #1;
    chk("msg_ready", {31'd0, msg_ready}, {31'd0, rdy});
    e.d  = ed;
    e.on = eon;
    e.bz = ebz;
    q.push_back(e);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      chk("digits", {16'd0, dig3, dig2, dig1, dig0}, {16'd0, mon_e.d});
      chk("disp_on", {31'd0, disp_on}, {31'd0, mon_e.on});
      chk("busy", {31'd0, busy}, {31'd0, mon_e.bz});
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_digits", {16'd0, dig3, dig2, dig1, dig0}, 32'd0);
    chk("rst_disp_on", {31'd0, disp_on}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // Status mirrored with one cycle latency
    repeat (3) cyc(16'h1234, 0, 0, 0, 0, 1, 16'h1234, 1, 0);

    // Plain message; status change during SHOW is ignored
    cyc(16'h1234, 1, 16'hABCD, 0, 0, 1, 16'hABCD, 1, 1);
    for (int i = 1; i < HOLD; i++)
      cyc(16'h5678, 0, 0, 0, 0, 1, 16'hABCD, 1, 1);
    cyc(16'h5678, 0, 0, 0, 0, 1, 16'h5678, 1, 0);

    // Blinking message: 1,1,0,0,1,1,0,0
    cyc(16'h5678, 1, 16'h1111, 1, 0, 1, 16'h1111, 1, 1);
    for (int i = 1; i < HOLD; i++)
      cyc(16'h5678, 0, 0, 0, 0, 1, 16'h1111, ((i / 2) % 2) == 0, 1);
    cyc(16'h5678, 0, 0, 0, 0, 1, 16'h5678, 1, 0);

    // Back-to-back with a third message held off
    cyc(16'h0042, 1, 16'h1111, 0, 0, 1, 16'h1111, 1, 1);
    for (int i = 1; i < 3; i++)
      cyc(16'h0042, 0, 0, 0, 0, 1, 16'h1111, 1, 1);
    cyc(16'h0042, 1, 16'h2222, 0, 0, 1, 16'h1111, 1, 1);
    for (int i = 4; i < HOLD; i++)
      cyc(16'h0042, 1, 16'h3333, 0, 0, 0, 16'h1111, 1, 1);
    cyc(16'h0042, 1, 16'h3333, 0, 0, 0, 16'h2222, 1, 1);
    cyc(16'h0042, 1, 16'h3333, 0, 0, 1, 16'h2222, 1, 1);
    for (int i = 2; i < HOLD; i++)
      cyc(16'h0042, 0, 0, 0, 0, 0, 16'h2222, 1, 1);
    cyc(16'h0042, 0, 0, 0, 0, 0, 16'h3333, 1, 1);
    for (int i = 1; i < HOLD; i++)
      cyc(16'h0042, 0, 0, 0, 0, 1, 16'h3333, 1, 1);
    cyc(16'h0042, 0, 0, 0, 0, 1, 16'h0042, 1, 0);

    // Transfer on the expiry edge restarts hold directly
    cyc(16'h0042, 1, 16'h4444, 0, 0, 1, 16'h4444, 1, 1);
    for (int i = 1; i < HOLD; i++)
      cyc(16'h0042, 0, 0, 0, 0, 1, 16'h4444, 1, 1);
    cyc(16'h0042, 1, 16'h5555, 0, 0, 1, 16'h5555, 1, 1);
    for (int i = 1; i < HOLD; i++)
      cyc(16'h0042, 0, 0, 0, 0, 1, 16'h5555, 1, 1);
    cyc(16'h0042, 0, 0, 0, 0, 1, 16'h0042, 1, 0);

    // Clear with pending message and an offer in the same cycle
    cyc(16'h0777, 1, 16'h6666, 0, 0, 1, 16'h6666, 1, 1);
    cyc(16'h0777, 1, 16'h7777, 0, 0, 1, 16'h6666, 1, 1);
    cyc(16'h0777, 0, 0, 0, 0, 0, 16'h6666, 1, 1);
    cyc(16'h0777, 1, 16'h8888, 0, 1, 0, 16'h0777, 1, 0);
    repeat (2) cyc(16'h0777, 0, 0, 0, 0, 1, 16'h0777, 1, 0);
    // Pending must really be gone: next message expires straight to status
    cyc(16'h0777, 1, 16'h0A0A, 0, 0, 1, 16'h0A0A, 1, 1);
    for (int i = 1; i < HOLD; i++)
      cyc(16'h0777, 0, 0, 0, 0, 1, 16'h0A0A, 1, 1);
    cyc(16'h0777, 0, 0, 0, 0, 1, 16'h0777, 1, 0);

    // Clear during the blink-off phase relights the display
    cyc(16'h0123, 1, 16'h9999, 1, 0, 1, 16'h9999, 1, 1);
    cyc(16'h0123, 0, 0, 0, 0, 1, 16'h9999, 1, 1);
    cyc(16'h0123, 0, 0, 0, 0, 1, 16'h9999, 0, 1);
    cyc(16'h0123, 0, 0, 0, 1, 0, 16'h0123, 1, 0);
    cyc(16'h0123, 0, 0, 0, 0, 1, 16'h0123, 1, 0);

    // Asynchronous reset mid-message
    cyc(16'h0456, 1, 16'hABCD, 0, 0, 1, 16'hABCD, 1, 1);
    cyc(16'h0456, 0, 0, 0, 0, 1, 16'hABCD, 1, 1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_digits", {16'd0, dig3, dig2, dig1, dig0}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_disp_on", {31'd0, disp_on}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    cyc(16'h0456, 0, 0, 0, 0, 1, 16'h0456, 1, 0);
    cyc(16'h0456, 0, 0, 0, 0, 1, 16'h0456, 1, 0);

    @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
